// File: rtl/spu_adsr_envelope_pkg.sv
// Shared SPU envelope definitions: phase and sequencer encodings, level limits
// and the per-phase rate-step ROM address function.
package spu_adsr_envelope_pkg;

  typedef enum logic [2:0] {
    PH_OFF     = 3'd0,
    PH_ATTACK  = 3'd1,
    PH_DECAY   = 3'd2,
    PH_SUSTAIN = 3'd3,
    PH_RELEASE = 3'd4
  } phase_e;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_REQ   = 2'd1,
    SEQ_WAIT  = 2'd2,
    SEQ_APPLY = 2'd3
  } seq_e;

  localparam logic [14:0] SPU_LEVEL_MAX = 15'h7FFF;
  localparam logic [14:0] SPU_EXP_KNEE  = 15'h6000;

  // Exponential attack steps 8 rate entries slower once past the knee.
  function automatic logic [6:0] rate_adrs(
    input phase_e      ph,
    input logic [14:0] level,
    input logic [14:0] knee,
    input logic [6:0]  attack_rate,
    input logic        attack_exp,
    input logic [3:0]  decay_shift,
    input logic [6:0]  sustain_rate,
    input logic [4:0]  release_rate
  );
    logic [7:0] slow;
    logic [6:0] adrs;
    slow = {1'b0, attack_rate} + 8'd8;
    adrs = '0;
    case (ph)
      PH_ATTACK:  adrs = (attack_exp && (level > knee)) ? (slow[7] ? 7'h7F : slow[6:0])
                                                        : attack_rate;
      PH_DECAY:   adrs = {1'b0, decay_shift, 2'b00};
      PH_SUSTAIN: adrs = sustain_rate;
      PH_RELEASE: adrs = {release_rate, 2'b00};
      default:    adrs = '0;
    endcase
    return adrs;
  endfunction

endpackage

// File: rtl/spu_adsr_envelope.sv
// Single-voice ADSR envelope stepper: per tick, reads one rate step from the
// external ROM and applies it linearly or exponentially to a 15-bit level.
module spu_adsr_envelope
  import spu_adsr_envelope_pkg::*;
#(
  parameter logic [14:0] LEVEL_MAX = SPU_LEVEL_MAX,
  parameter logic [14:0] EXP_KNEE  = SPU_EXP_KNEE
) (
  input  logic        m_clock,
  input  logic        p_reset,
  input  logic        tick,
  input  logic        key_on,
  input  logic        key_off,
  input  logic [6:0]  attack_rate,
  input  logic        attack_exp,
  input  logic [3:0]  decay_shift,
  input  logic [3:0]  sustain_level,
  input  logic [6:0]  sustain_rate,
  input  logic        sustain_dec,
  input  logic        sustain_exp,
  input  logic [4:0]  release_rate,
  input  logic        release_exp,
  output logic        rom_read,
  output logic [6:0]  rom_adrs,
  input  logic [14:0] rom_dout,
  output logic [14:0] env_level,
  output logic [2:0]  phase,
  output logic        busy,
  output logic        tick_overrun
);

  seq_e               seq_q;
  phase_e             phase_q, phase_d;
  logic [14:0]        level_q, level_d;
  logic signed [15:0] step_q;
  logic               rom_read_q, busy_q, overrun_q;
  logic [6:0]         rom_adrs_q;

  logic               increasing, exp_dec;
  logic signed [16:0] lin_delta, exp_delta, delta, sum;
  logic [16:0]        sustain_thr;

  always_comb begin
    increasing  = (phase_q == PH_ATTACK) || ((phase_q == PH_SUSTAIN) && !sustain_dec);
    exp_dec     = (phase_q == PH_DECAY) ||
                  ((phase_q == PH_SUSTAIN) && sustain_exp) ||
                  ((phase_q == PH_RELEASE) && release_exp);
    lin_delta   = {step_q[15], step_q};
    // 15x15 signed product; arithmetic shift floors toward -inf.
    exp_delta   = 17'(($signed({{16{step_q[15]}}, step_q}) *
                       $signed({17'b0, level_q})) >>> 15);
    delta       = increasing ? -lin_delta : (exp_dec ? exp_delta : lin_delta);
    sum         = $signed({2'b00, level_q}) + delta;
    sustain_thr = ({13'b0, sustain_level} + 17'd1) << 11;

    if (sum < 0)
      level_d = '0;
    else if (sum > $signed({2'b00, LEVEL_MAX}))
      level_d = LEVEL_MAX;
    else
      level_d = sum[14:0];

    phase_d = phase_q;
    case (phase_q)
      PH_ATTACK:  if (level_d == LEVEL_MAX) phase_d = PH_DECAY;
      PH_DECAY:   if ({2'b00, level_d} <= sustain_thr) phase_d = PH_SUSTAIN;
      PH_RELEASE: if (level_d == '0) phase_d = PH_OFF;
      default:    phase_d = phase_q;
    endcase
  end

  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) begin
      seq_q      <= SEQ_IDLE;
      phase_q    <= PH_OFF;
      level_q    <= '0;
      step_q     <= '0;
      rom_read_q <= 1'b0;
      rom_adrs_q <= '0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      rom_read_q <= 1'b0;
      // Key events abort any in-flight update and swallow a coincident tick.
      if (key_on) begin
        level_q <= '0;
        phase_q <= PH_ATTACK;
        seq_q   <= SEQ_IDLE;
        busy_q  <= 1'b0;
      end else if (key_off && (phase_q != PH_OFF)) begin
        phase_q <= PH_RELEASE;
        seq_q   <= SEQ_IDLE;
        busy_q  <= 1'b0;
      end else begin
        if (tick && (seq_q != SEQ_IDLE))
          overrun_q <= 1'b1;
        case (seq_q)
          SEQ_IDLE: begin
            if (tick && (phase_q != PH_OFF)) begin
              seq_q      <= SEQ_REQ;
              busy_q     <= 1'b1;
              rom_read_q <= 1'b1;
              rom_adrs_q <= rate_adrs(phase_q, level_q, EXP_KNEE, attack_rate, attack_exp,
                                      decay_shift, sustain_rate, release_rate);
            end
          end
          SEQ_REQ:  seq_q <= SEQ_WAIT;
          SEQ_WAIT: begin
            step_q <= {rom_dout[14], rom_dout};
            seq_q  <= SEQ_APPLY;
          end
          SEQ_APPLY: begin
            level_q <= level_d;
            phase_q <= phase_d;
            seq_q   <= SEQ_IDLE;
            busy_q  <= 1'b0;
          end
          default: seq_q <= SEQ_IDLE;
        endcase
      end
    end
  end

  assign rom_read     = rom_read_q;
  assign rom_adrs     = rom_adrs_q;
  assign env_level    = level_q;
  assign phase        = phase_q;
  assign busy         = busy_q;
  assign tick_overrun = overrun_q;

endmodule

// File: doc/spu_adsr_envelope.md
Name: spu_adsr_envelope

Overview:
- Single-voice ADSR envelope stepper for the SPU; the read-side consumer of the 128-entry rate step ROM (7-bit address, 15-bit signed step, 1-cycle registered read latency).
- On each sample tick it computes the rate address for the current phase and reads the ROM.
- It then applies the step, linear or exponential, to a 15-bit envelope level and advances the ADSR phase.
- Instantiated once per voice in the SPU voice pipeline; the ROM is instantiated beside it.

Parameters:
LEVEL_MAX, 15'h7FFF, envelope ceiling
EXP_KNEE, 15'h6000, exponential attack slows above this level

Ports:
m_clock  in  1  clock
p_reset  in  1  asynchronous active-high reset
tick  in  1  sample strobe, one cycle wide
key_on  in  1  pulse: restart envelope
key_off  in  1  pulse: enter release
attack_rate  in  7  attack rate
attack_exp  in  1  exponential attack
decay_shift  in  4  decay rate
sustain_level  in  4  sustain threshold
sustain_rate  in  7  sustain rate
sustain_dec  in  1  1 = sustain decreases
sustain_exp  in  1  exponential sustain
release_rate  in  5  release rate
release_exp  in  1  exponential release
rom_read  out  1  ROM read strobe
rom_adrs  out  7  ROM address
rom_dout  in  15  ROM step data, valid 1 cycle after rom_read
env_level  out  15  current envelope level
phase  out  3  OFF=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4
busy  out  1  update in flight
tick_overrun  out  1  sticky: tick arrived while busy

Behaviour:
- Reset (async, p_reset=1) forces:
  - env_level=0, phase=OFF, busy=0
  - rom_read=0, rom_adrs=0, tick_overrun=0
  - update sequencer to IDLE.
- Update sequencer states: IDLE, REQ, WAIT, APPLY.
  - IDLE: a tick with phase!=OFF goes to REQ. A tick with phase=OFF is ignored.
  - REQ (cycle 1): rom_read=1; rom_adrs = phase rate address; go to WAIT.
  - WAIT (cycle 2): capture rom_dout sign-extended as S (S<=0); go to APPLY.
  - APPLY (cycle 3): compute and write env_level and phase; go to IDLE.
  - env_level is visible updated 3 cycles after the tick.
  - busy=1 in REQ, WAIT and APPLY.
- Overrun: a tick seen while busy=1 is dropped and sets tick_overrun. tick_overrun clears only on reset.
- Rate address by phase, saturating at 7'h7F:
  - ATTACK: attack_rate. If attack_exp=1 and env_level>EXP_KNEE, use attack_rate+8.
  - DECAY: {decay_shift,2'b00}
  - SUSTAIN: sustain_rate
  - RELEASE: {release_rate,2'b00}
- Step arithmetic:
  - Increasing (ATTACK, or SUSTAIN with sustain_dec=0): delta = -S.
  - Decreasing linear: delta = S.
  - Decreasing exponential (DECAY always; SUSTAIN with sustain_exp=1; RELEASE with release_exp=1): delta = (S*env_level)>>>15, a 30-bit signed product shifted arithmetically (floors).
  - new = env_level + delta in 17-bit signed, clamped to [0, LEVEL_MAX].
  - ROM addresses >=0x39 return 0, so the level holds.
- Phase transitions, evaluated in APPLY on the clamped value:
  - ATTACK: new==LEVEL_MAX moves to DECAY.
  - DECAY: new <= (sustain_level+1)*16'h0800 moves to SUSTAIN.
  - SUSTAIN: never leaves by itself.
  - RELEASE: new==0 moves to OFF.
- key_on (any state): env_level=0 and phase=ATTACK on the next edge. An in-flight update is aborted (sequencer to IDLE, no write).
- key_off: if phase!=OFF, phase=RELEASE on the next edge and any in-flight update is aborted. If phase=OFF, key_off is ignored.
- key_on and key_off in the same cycle: key_on wins.
- A key event coincident with a tick: the key takes effect and the tick is dropped; tick_overrun is not set.
- Config inputs are sampled in REQ (rate address) and APPLY (mode bits and thresholds).

Decomposition:
- Shared SPU package holds:
  - phase encoding constants
  - LEVEL_MAX and EXP_KNEE
  - sequencer state encoding
  - the rate-address function.
- No sub-module is required. The exponential multiply (15x15 signed) is coded inline; the ROM remains external.

Test Plan:
- Linear attack, attack_rate=0, from key_on: tick1 gives 16384; tick2 clamps to 32767 and phase=DECAY. Each update lands exactly 3 cycles after its tick.
- Decay, decay_shift=0, sustain_level=7, level 32767: one tick gives S=-16384, delta=-16384, level 16383 <= 16384, phase=SUSTAIN.
- Linear release, release_rate=0, release_exp=0, from 32767: key_off then tick gives 16383, next tick gives 0 and phase=OFF. Further ticks do nothing.
- Slow sustain, sustain_rate=7'h7F: 10 ticks leave env_level unchanged and phase=SUSTAIN.
- Tick while busy: second tick one cycle after the first sets tick_overrun=1 with only one level update. Key_on asserted in WAIT aborts the update: level=0, phase=ATTACK.
- Async reset asserted mid-APPLY, between clock edges: all outputs return to 0/OFF immediately, and a tick after release of reset is ignored while phase=OFF.
